// File: rtl/bank_access_arbiter_if.sv
// Request/grant bundle between two bank requesters (A, B) and the bank arbiter, plus the scan outputs.
// The master modport is the requester side; the slave modport is the arbiter.
interface bank_access_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 2
);
  logic             req_a;
  logic             we_a;
  logic [AW-1:0]    addr_a;
  logic [WIDTH-1:0] wdata_a;
  logic             gnt_a;
  logic [WIDTH-1:0] rdata_a;

  logic             req_b;
  logic             we_b;
  logic [AW-1:0]    addr_b;
  logic [WIDTH-1:0] wdata_b;
  logic             gnt_b;
  logic [WIDTH-1:0] rdata_b;

  logic             err;
  logic [WIDTH-1:0] scan_data;
  logic [AW-1:0]    scan_idx;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, rdata_a, gnt_b, rdata_b, err, scan_data, scan_idx
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, rdata_a, gnt_b, rdata_b, err, scan_data, scan_idx
  );
endinterface

// File: rtl/bank_access_arbiter.sv
// Round-robin arbiter sharing a DEPTH-slot register bank between requesters A and B; BANK_SCAN_EN adds a slot scanner.
// Latency: grant, write commit and read data one cycle after the request is sampled; backpressure: req held until its gnt.
module bank_access_arbiter #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 3,
  parameter int AW       = 2,
  parameter int SCAN_DIV = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bank_access_arbiter_if.slave  bus
);

  if (SCAN_DIV < 1 || DEPTH < 2 || DEPTH > (1 << AW)) begin : g_param_check
    $error("bank_access_arbiter: invalid WIDTH/DEPTH/AW/SCAN_DIV combination");
  end

  typedef enum logic {PREF_A, PREF_B} ptr_e;

  ptr_e             ptr_q, ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             elig_a, elig_b, win_a, win_b, win_any;
  logic             sel_we, hit;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_wdata, rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PREF_A;
    else        ptr_q <= ptr_d;
  end

  // A requester granted last cycle sits out this one, which is what makes contention alternate.
  always_comb begin
    elig_a    = bus.req_a & ~bus.gnt_a;
    elig_b    = bus.req_b & ~bus.gnt_b;
    win_a     = elig_a & (~elig_b | (ptr_q == PREF_A));
    win_b     = elig_b & (~elig_a | (ptr_q == PREF_B));
    win_any   = win_a | win_b;
    ptr_d     = ptr_q;
    if (win_a)      ptr_d = PREF_B;
    else if (win_b) ptr_d = PREF_A;
    sel_we    = win_a ? bus.we_a    : bus.we_b;
    sel_addr  = win_a ? bus.addr_a  : bus.addr_b;
    sel_wdata = win_a ? bus.wdata_a : bus.wdata_b;
    hit       = 1'b0;
    rd        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_addr == AW'(i)) begin
        hit = 1'b1;
        rd  = mem[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.gnt_a   <= 1'b0;
      bus.gnt_b   <= 1'b0;
      bus.err     <= 1'b0;
      bus.rdata_a <= '0;
      bus.rdata_b <= '0;
    end else begin
      bus.gnt_a <= win_a;
      bus.gnt_b <= win_b;
      bus.err   <= win_any & ~hit;
      if (win_a & ~bus.we_a) bus.rdata_a <= rd;
      if (win_b & ~bus.we_b) bus.rdata_b <= rd;
      // Out-of-range writes never match a slot, so they drop silently.
      for (int i = 0; i < DEPTH; i++) begin
        if (win_any && sel_we && sel_addr == AW'(i)) mem[i] <= sel_wdata;
      end
    end
  end

`ifdef BANK_SCAN_EN
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0]    div_q;
  logic [WIDTH-1:0] scan_rd;

  always_comb begin
    scan_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.scan_idx == AW'(i)) scan_rd = mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      bus.scan_idx  <= '0;
      bus.scan_data <= '0;
    end else begin
      bus.scan_data <= scan_rd;
      if (div_q == CW'(SCAN_DIV - 1)) begin
        div_q        <= '0;
        bus.scan_idx <= (bus.scan_idx == AW'(DEPTH - 1)) ? '0 : bus.scan_idx + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end
`else
  assign bus.scan_data = '0;
  assign bus.scan_idx  = '0;
`endif

endmodule

// File: doc/bank_access_arbiter.md
Name: bank_access_arbiter

Overview:
- Owns a small DEPTH-slot register bank (default 3 slots × 4 bits) and shares it between two requesters, A and B.
- A is the debounced front-panel path; B is the secondary/control path.
- Arbitration is round-robin with a registered, single-cycle grant. A write commits, or read data returns, in the grant cycle.
- Sits between the button front-end (debouncer / edge-detector) and the display/output logic.

Parameters:
- WIDTH, 4, data width of each slot.
- DEPTH, 3, number of slots (2..2^AW).
- AW, 2, address width.
- SCAN_DIV, 8, cycles per slot in scan mode (≥1; used only with BANK_SCAN_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_a  in  1  requester A access request, level, held until gnt_a.
- we_a  in  1  A: 1 = write, 0 = read; held with req_a.
- addr_a  in  AW  A slot address.
- wdata_a  in  WIDTH  A write data.
- gnt_a  out  1  A grant, 1-cycle pulse; access performed.
- rdata_a  out  WIDTH  A read data, valid while gnt_a=1.
- req_b, we_b, addr_b, wdata_b, gnt_b, rdata_b: same as the A ports, for requester B.
- err  out  1  1-cycle pulse alongside a grant whose address is ≥ DEPTH.
- scan_data  out  WIDTH  scan output (see Optional Feature).
- scan_idx  out  AW  slot currently on scan_data.

Behaviour:
- Reset (async, rst_n=0) clears:
  - all slots to 0;
  - gnt_a, gnt_b, err, rdata_a, rdata_b, scan_data, scan_idx to 0;
  - the priority pointer to "A preferred".
- Eligibility: requester X is eligible in cycle t if req_x=1 and gnt_x=0 in cycle t. A requester cannot be granted in two consecutive cycles.
- Arbitration in cycle t, over eligible requesters only:
  - none eligible → no grant;
  - exactly one eligible → that requester wins;
  - both eligible → the pointer-preferred one wins.
- Grant timing: at the clk edge ending cycle t, gnt_winner←1 for exactly cycle t+1, and the other gnt←0.
- Access happens at that same edge, using the winner's inputs as sampled in cycle t:
  - write: slot[addr]←wdata. The new value is visible to any read granted from cycle t+2 onward.
  - read: rdata_winner←slot[addr], using the pre-write bank contents.
- rdata_x holds its last value when not granted; it is only meaningful while gnt_x=1.
- Pointer: after every grant, the pointer prefers the loser (the requester that did not win).
- Contention behaviour: with both req held continuously, grants alternate A, B, A, B… one per cycle; neither requester waits more than 1 cycle past eligibility.
- Requester protocol:
  - keep req/we/addr/wdata stable until gnt is seen;
  - deassert req in the gnt cycle, or keep req asserted for a new transaction presented with new we/addr/wdata that same cycle.
- Out-of-range address (addr ≥ DEPTH): the grant is still issued and err=1 in the grant cycle. A write is dropped; a read returns 0.
- Address 3 with DEPTH=3 is therefore an error address.
- Same-slot write conflict: cannot occur, because only one access executes per cycle.
- Reset mid-transaction: all pending state is discarded. Requests still high after rst_n deasserts are arbitrated afresh from "A preferred".

Optional Feature:
- Macro: BANK_SCAN_EN.
- Defined:
  - a free-running divider advances scan_idx every SCAN_DIV cycles: 0,1,…,DEPTH-1,0 (wrap);
  - scan_data is registered slot[scan_idx] and reflects writes 1 cycle after commit;
  - scan_data does not interact with arbitration.
- Not defined: scan_data=0 and scan_idx=0 constantly, and no divider logic is present.

Test Plan:
- Reset, then A writes 4'hA to addr 1 → gnt_a pulses 1 cycle later. A then reads addr 1 → rdata_a=4'hA with gnt_a; err=0.
- req_a and req_b asserted together and held for 4 cycles after reset → grants A, B, A, B on consecutive cycles; no cycle has both gnt=1.
- B writes 4'h5 to addr 2 while A reads addr 2 in the same cycle (A wins) → rdata_a=old value 0. A's next read of addr 2 → 4'h5.
- A writes 4'hF to addr 3 (DEPTH=3) → gnt_a=1, err=1, no slot changes. A read of addr 3 → rdata_a=0, err=1.
- rst_n pulsed low mid-contention with slots {1,2,3} → all outputs 0 immediately. After release with req_b only high → gnt_b in the first cycle after it is sampled; reads return 0.
- With BANK_SCAN_EN, SCAN_DIV=2, slots {3,6,9} → scan_data sequence 3,3,6,6,9,9,3…; scan_idx wraps 2→0.
